uart_cmd_parser: RTL
====================

# uart_cmd_parser

Byte-level command framer directly downstream of `uart_rx`. Consumes each received byte via the `rx_done`/`rx_trigger` handshake, hunts for a sync byte, assembles an opcode, length and up to `MAX_LEN` payload bytes, and verifies an XOR checksum. Each valid frame is presented to the tester control logic as one parallel command word with a valid/ready handshake. Malformed frames, over-length frames and stalled frames are reported on a one-cycle error strobe.

## Interface
- `MAX_LEN`, 8: maximum payload bytes, 1..15.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `TIMEOUT_CYCLES`, 100_000_000/9600*20: maximum `clk` cycles between bytes inside a frame.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `rx_buffer`  in  8  byte from `uart_rx`.
- `rx_done`  in  1  level; byte available (held high until `rx_trigger`).
- `rx_trigger`  out  1  one-cycle pulse; releases `uart_rx` for the next byte.
- `cmd_valid`  out  1  frame available; held until accepted.
- `cmd_ready`  in  1  consumer accepts the frame when sampled high with `cmd_valid`.
- `cmd_op`  out  8  opcode byte.
- `cmd_len`  out  4  payload byte count.
- `cmd_payload`  out  8*MAX_LEN  payload byte i at [8i+7:8i]; unused bytes are zero.
- `frame_err`  out  1  one-cycle error strobe.
- `err_code`  out  2  1 = length > MAX_LEN, 2 = checksum mismatch, 3 = timeout; valid while `frame_err` is high, otherwise holds its last value.

## Operation
- Byte accept condition: `rx_done==1 && rx_trigger==0 && state!=HOLD`. The second term masks the stale `rx_done` during the trigger cycle.
- On every accept, `rx_trigger` goes high for exactly one cycle, on the next cycle.
- The running checksum `csum[7:0]` XORs OP, LEN and every payload byte. SYNC is excluded.
- States:
  - IDLE: accepted byte == SYNC_BYTE clears `csum`, `cmd_payload` and the byte index, then goes to OP. Other bytes are consumed and discarded with no error.
  - OP: latch `cmd_op`, update csum, go to LEN.
  - LEN: if the value exceeds MAX_LEN (full 8-bit compare), strobe err 1 and go to IDLE. Otherwise latch `cmd_len` (low 4 bits). A value of 0 goes to CSUM; any other value goes to PAYLOAD.
  - PAYLOAD: store the byte at the current index, increment the index, update csum. After byte `cmd_len-1`, go to CSUM.
  - CSUM: if the byte == `csum`, go to HOLD with `cmd_valid=1`. Otherwise strobe err 2 and go to IDLE.
  - HOLD: no bytes accepted; `uart_rx` holds or drops further input. On `cmd_valid && cmd_ready`, clear `cmd_valid` and go to IDLE.
- Timeout counter:
  - Runs in OP, LEN, PAYLOAD and CSUM.
  - Cleared on every accept and in IDLE and HOLD.
  - At TIMEOUT_CYCLES-1: strobe err 3 and go to IDLE.
  - If a byte is accepted in the same cycle as the timeout, the byte wins and there is no error.
- `cmd_op`, `cmd_len` and `cmd_payload` are stable while `cmd_valid` is high. Outside HOLD they are don't-care but deterministic.

## Timing
- Reset (async assert, sync release): state IDLE; `rx_trigger`, `cmd_valid`, `frame_err` = 0; `err_code`, `cmd_op`, `cmd_len`, `cmd_payload`, `csum` and counters = 0.
- Reset mid-frame discards the partial frame with no error strobe.
- Accept at edge N gives `rx_trigger` high during cycle N+1. `uart_rx` clears `rx_done` at edge N+2, so the earliest next accept is edge N+2.
- Checksum byte accepted at edge N gives `cmd_valid` high from cycle N+1.
- `cmd_ready` may be high before `cmd_valid`. The transfer occurs at the first edge where both are high. `cmd_valid` is low the following cycle, and a new SYNC can be accepted at that same edge+1.
- `frame_err` is high for exactly one cycle after the offending accept or timeout edge.
- `rx_trigger` for an erroring byte is still issued normally.

## Test plan
- Frame A5 10 03 11 22 33 (csum 10^03^11^22^33 = 0x13), `cmd_ready=1` → one `cmd_valid` cycle with op=0x10, len=3, payload=0x...332211, upper bytes zero.
- Frame A5 42 00 42 (csum 0x42) → `cmd_valid`, op=0x42, len=0, payload=0.
- Frame A5 10 01 55 00 (bad csum) → `frame_err` high 1 cycle, err_code=2, no `cmd_valid`. A following good frame is received correctly.
- Frame A5 10 09 with MAX_LEN=8 → err_code=1. Subsequent bytes are discarded until the next A5.
- A5 10, then silence for TIMEOUT_CYCLES → err_code=3 exactly TIMEOUT_CYCLES after the last accept. The state returns to IDLE.
- Good frame with `cmd_ready=0` for 50 cycles while `rx_done` stays high → `cmd_valid` held, no `rx_trigger`, outputs stable. `rst_n` pulsed mid-frame → all outputs 0, IDLE.

Source files
------------

// File: rtl/uart_cmd_parser_if.sv
// Byte stream from uart_rx and the parsed command/err strobe toward tester control.
// master = the parser; slave = the uart_rx + consumer side.
interface uart_cmd_parser_if #(
  parameter int unsigned MAX_LEN = 8
);
  logic [7:0]             rx_buffer;
  logic                   rx_done;
  logic                   rx_trigger;
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [7:0]             cmd_op;
  logic [3:0]             cmd_len;
  logic [8*MAX_LEN-1:0]   cmd_payload;
  logic                   frame_err;
  logic [1:0]             err_code;

  modport master (
    input  rx_buffer, rx_done, cmd_ready,
    output rx_trigger, cmd_valid, cmd_op, cmd_len, cmd_payload, frame_err, err_code
  );

  modport slave (
    output rx_buffer, rx_done, cmd_ready,
    input  rx_trigger, cmd_valid, cmd_op, cmd_len, cmd_payload, frame_err, err_code
  );
endinterface

// File: rtl/uart_cmd_parser.sv
// Frames SYNC/OP/LEN/payload/XOR-checksum byte streams from uart_rx into one command word,
// with an error strobe for over-length, bad checksum and inter-byte timeout.
module uart_cmd_parser #(
  parameter int unsigned MAX_LEN        = 8,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000 / 9600 * 20
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_cmd_parser_if.master   bus
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_OP      = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CSUM    = 3'd4,
    S_HOLD    = 3'd5
  } state_e;

  state_e                  state_q, state_d;
  logic                    trig_q, trig_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;
  logic [1:0]              err_code_q, err_code_d;
  logic [7:0]              op_q, op_d;
  logic [3:0]              len_q, len_d;
  logic [MAX_LEN-1:0][7:0] payload_q, payload_d;
  logic [3:0]              idx_q, idx_d;
  logic [7:0]              csum_q, csum_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    accept_c;

  // The trigger term masks rx_done that is still high while uart_rx sees the release pulse.
  assign accept_c = bus.rx_done && !trig_q && (state_q != S_HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      trig_q     <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
      op_q       <= 8'd0;
      len_q      <= 4'd0;
      payload_q  <= '0;
      idx_q      <= 4'd0;
      csum_q     <= 8'd0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      trig_q     <= trig_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      op_q       <= op_d;
      len_q      <= len_d;
      payload_q  <= payload_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    trig_d     = accept_c;
    valid_d    = valid_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    op_d       = op_q;
    len_d      = len_q;
    payload_d  = payload_q;
    idx_d      = idx_q;
    csum_d     = csum_q;
    cnt_d      = cnt_q;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept_c && (bus.rx_buffer == SYNC_BYTE)) begin
          csum_d    = 8'd0;
          payload_d = '0;
          idx_d     = 4'd0;
          state_d   = S_OP;
        end
      end
      S_HOLD: begin
        cnt_d = '0;
        if (bus.cmd_ready) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        // A byte arriving on the timeout edge takes priority over the timeout.
        if (accept_c) begin
          cnt_d = '0;
          case (state_q)
            S_OP: begin
              op_d    = bus.rx_buffer;
              csum_d  = csum_q ^ bus.rx_buffer;
              state_d = S_LEN;
            end
            S_LEN: begin
              if (bus.rx_buffer > 8'(MAX_LEN)) begin
                err_d      = 1'b1;
                err_code_d = 2'd1;
                state_d    = S_IDLE;
              end else begin
                len_d   = bus.rx_buffer[3:0];
                csum_d  = csum_q ^ bus.rx_buffer;
                state_d = (bus.rx_buffer == 8'd0) ? S_CSUM : S_PAYLOAD;
              end
            end
            S_PAYLOAD: begin
              for (int unsigned i = 0; i < MAX_LEN; i++) begin
                if (idx_q == 4'(i)) payload_d[i] = bus.rx_buffer;
              end
              idx_d  = idx_q + 4'd1;
              csum_d = csum_q ^ bus.rx_buffer;
              if ((idx_q + 4'd1) == len_q) state_d = S_CSUM;
            end
            S_CSUM: begin
              if (bus.rx_buffer == csum_q) begin
                valid_d = 1'b1;
                state_d = S_HOLD;
              end else begin
                err_d      = 1'b1;
                err_code_d = 2'd2;
                state_d    = S_IDLE;
              end
            end
            default: state_d = S_IDLE;
          endcase
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          cnt_d      = '0;
          err_d      = 1'b1;
          err_code_d = 2'd3;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    endcase
  end

  assign bus.rx_trigger  = trig_q;
  assign bus.cmd_valid   = valid_q;
  assign bus.frame_err   = err_q;
  assign bus.err_code    = err_code_q;
  assign bus.cmd_op      = op_q;
  assign bus.cmd_len     = len_q;
  assign bus.cmd_payload = payload_q;

endmodule
